// File: rtl/wb_arbiter.sv
// Four-requester writeback arbiter with burst locking and a registered output stage.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin IDLE arbitration; the default build uses fixed priority (0 highest).
module wb_arbiter #(
   parameter int LENGTH = 32,
   parameter int TAG_W  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            req_valid,
   input  logic [3:0]            req_last,
   input  logic [4*LENGTH-1:0]   req_data,
   input  logic [4*TAG_W-1:0]    req_tag,
   output logic [3:0]            req_ready,
   input  logic                  wb_stall,
   output logic                  wb_valid,
   output logic [LENGTH-1:0]     wb_data,
   output logic [TAG_W-1:0]      wb_tag,
   output logic [1:0]            wb_src,
   output logic                  dbg_state
);

   // Handshake: a beat moves when req_valid[i] && req_ready[i]; ready never depends on the
   // requester having already seen ready, and a stalled, full output stage withholds every grant.
   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t              state, state_next;
   logic [1:0]          lock_id;
   logic [1:0]          gnt_idx;
   logic                gnt_ok;
   logic                gnt_last;
   logic                free;
   logic                xfer;
   logic [LENGTH-1:0]   sel_data;
   logic [TAG_W-1:0]    sel_tag;

`ifdef WB_ARB_ROUND_ROBIN_EN
   logic [1:0]          ptr;
`endif

   assign free      = !wb_valid || !wb_stall;
   assign xfer      = rst && free && gnt_ok;
   assign gnt_last  = req_last[gnt_idx];
   assign dbg_state = state;

   // Candidate selection; scanning from the far end lets the nearest valid requester win.
   always_comb begin
      gnt_ok  = 1'b0;
      gnt_idx = 2'd0;
      if (state == LOCKED) begin
         gnt_idx = lock_id;
         gnt_ok  = req_valid[lock_id];
      end else begin
`ifdef WB_ARB_ROUND_ROBIN_EN
         for (int k = 3; k >= 0; k--) begin
            if (req_valid[ptr + 2'(k)]) begin
               gnt_ok  = 1'b1;
               gnt_idx = ptr + 2'(k);
            end
         end
`else
         for (int k = 3; k >= 0; k--) begin
            if (req_valid[k]) begin
               gnt_ok  = 1'b1;
               gnt_idx = 2'(k);
            end
         end
`endif
      end
   end

   always_comb begin
      sel_data = '0;
      sel_tag  = '0;
      for (int i = 0; i < 4; i++) begin
         if (gnt_idx == 2'(i)) begin
            sel_data = req_data[i*LENGTH +: LENGTH];
            sel_tag  = req_tag[i*TAG_W +: TAG_W];
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // FSM next state
   always_comb begin
      state_next = state;
      if (xfer) begin
         if (state == IDLE && !gnt_last)       state_next = LOCKED;
         else if (state == LOCKED && gnt_last) state_next = IDLE;
      end
   end

   // FSM outputs
   always_comb begin
      req_ready = 4'b0000;
      if (xfer) req_ready[gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst)                                      lock_id <= 2'd0;
      else if (xfer && state == IDLE && !gnt_last)   lock_id <= gnt_idx;
   end

`ifdef WB_ARB_ROUND_ROBIN_EN
   // The pointer only moves when a burst finishes, so a locked burst never disturbs fairness.
   always_ff @(posedge clk) begin
      if (!rst)                  ptr <= 2'd0;
      else if (xfer && gnt_last) ptr <= gnt_idx + 2'd1;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_valid <= 1'b0;
         wb_data  <= '0;
         wb_tag   <= '0;
         wb_src   <= 2'd0;
      end else if (xfer) begin
         wb_valid <= 1'b1;
         wb_data  <= sel_data;
         wb_tag   <= sel_tag;
         wb_src   <= gnt_idx;
      end else if (free) begin
         wb_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Table-driven bench for wb_arbiter: each row drives one cycle and carries the expected grant,
// granted beats go through a scoreboard queue and are compared when they appear on the output.
module tb_wb_arbiter;
   localparam int LENGTH = 32;
   localparam int TAG_W  = 5;
   localparam int BW     = 2 + TAG_W + LENGTH;

   logic                 clk;
   logic                 rst;
   logic [3:0]           req_valid;
   logic [3:0]           req_last;
   logic [4*LENGTH-1:0]  req_data;
   logic [4*TAG_W-1:0]   req_tag;
   logic [3:0]           req_ready;
   logic                 wb_stall;
   logic                 wb_valid;
   logic [LENGTH-1:0]    wb_data;
   logic [TAG_W-1:0]     wb_tag;
   logic [1:0]           wb_src;
   logic                 dbg_state;

   wb_arbiter #(.LENGTH(LENGTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
      .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
      .wb_stall(wb_stall), .wb_valid(wb_valid), .wb_data(wb_data),
      .wb_tag(wb_tag), .wb_src(wb_src), .dbg_state(dbg_state)
   );

   typedef struct {
      logic       rst;
      logic [3:0] valid;
      logic [3:0] last;
      logic       stall;
      logic [3:0] exp_fp;
      logic [3:0] exp_rr;
      logic       exp_lock;
   } vec_t;

   vec_t           vecs[$];
   logic [BW-1:0]  exp_q[$];
   logic [BW-1:0]  last_beat;
   logic           exp_v;
   int             checks;
   int             errors;
   int             row;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic s,
                      input logic [3:0] efp, input logic [3:0] err, input logic lk);
      vec_t t;
      t.rst = r; t.valid = v; t.last = l; t.stall = s;
      t.exp_fp = efp; t.exp_rr = err; t.exp_lock = lk;
      vecs.push_back(t);
   endtask

   function automatic int onehot_idx(input logic [3:0] oh);
      int r;
      r = 0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = i;
      return r;
   endfunction

   task automatic apply(input vec_t v);
      logic [3:0] er;
      int         idx;
      @(negedge clk);
      rst       = v.rst;
      req_valid = v.valid;
      req_last  = v.last;
      wb_stall  = v.stall;
      for (int i = 0; i < 4; i++) begin
         req_data[i*LENGTH +: LENGTH] = $urandom;
         req_tag[i*TAG_W +: TAG_W]    = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
      end
`ifdef WB_ARB_ROUND_ROBIN_EN
      er = v.exp_rr;
`else
      er = v.exp_fp;
`endif
      #1;
      check("req_ready", 64'(req_ready), 64'(er));
      if (er != 4'b0000) begin
         idx = onehot_idx(er);
         exp_q.push_back({2'(idx), req_tag[idx*TAG_W +: TAG_W], req_data[idx*LENGTH +: LENGTH]});
      end
      @(posedge clk);
      #1;
      if (!v.rst) begin
         exp_v     = 1'b0;
         last_beat = '0;
      end else if (er != 4'b0000) begin
         exp_v = 1'b1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty row %0d: got no queued beat expected one", row);
         end else begin
            last_beat = exp_q.pop_front();
         end
      end else if (!(v.stall && exp_v)) begin
         exp_v = 1'b0;
      end
      check("wb_valid", 64'(wb_valid), 64'(exp_v));
      check("wb_beat", 64'({wb_src, wb_tag, wb_data}), 64'(last_beat));
      check("fsm_state", 64'(dbg_state), 64'(v.exp_lock));
   endtask

   initial begin
      checks = 0; errors = 0; row = 0;
      exp_v = 1'b0; last_beat = '0;
      rst = 1'b0; req_valid = 4'b0; req_last = 4'b0; wb_stall = 1'b0;
      req_data = '0; req_tag = '0;

      // rst, valid, last, stall, expected grant (fixed), expected grant (round-robin), locked after edge
      add(0, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0);
      add(0, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0);
      // all valid, single beats: rotation vs fixed priority
      add(1, 4'b1111, 4'b1111, 0, 4'b0001, 4'b0001, 0);
      add(1, 4'b1111, 4'b1111, 0, 4'b0001, 4'b0010, 0);
      add(1, 4'b1111, 4'b1111, 0, 4'b0001, 4'b0100, 0);
      add(1, 4'b1111, 4'b1111, 0, 4'b0001, 4'b1000, 0);
      add(1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
      // three-beat burst from requester 2 with 0 and 1 waiting
      add(1, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0100, 1);
      add(1, 4'b0111, 4'b0000, 0, 4'b0100, 4'b0100, 1);
      add(1, 4'b0111, 4'b0100, 0, 4'b0100, 4'b0100, 0);
      add(1, 4'b0011, 4'b0011, 0, 4'b0001, 4'b0001, 0);
      add(1, 4'b0011, 4'b0011, 0, 4'b0001, 4'b0010, 0);
      add(1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
      // stall holds a full output stage for three cycles
      add(1, 4'b0001, 4'b0001, 0, 4'b0001, 4'b0001, 0);
      add(1, 4'b0001, 4'b0001, 1, 4'b0000, 4'b0000, 0);
      add(1, 4'b0001, 4'b0001, 1, 4'b0000, 4'b0000, 0);
      add(1, 4'b0001, 4'b0001, 1, 4'b0000, 4'b0000, 0);
      add(1, 4'b0001, 4'b0001, 0, 4'b0001, 4'b0001, 0);
      add(1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
      // stall with an empty output stage still grants
      add(1, 4'b0010, 4'b0010, 1, 4'b0010, 4'b0010, 0);
      add(1, 4'b0010, 4'b0010, 1, 4'b0000, 4'b0000, 0);
      add(1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
      // locked on 3, requester 3 drops out while 0 is valid
      add(1, 4'b1000, 4'b0000, 0, 4'b1000, 4'b1000, 1);
      add(1, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 1);
      add(1, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 1);
      add(1, 4'b1001, 4'b1000, 0, 4'b1000, 4'b1000, 0);
      add(1, 4'b1001, 4'b1001, 0, 4'b0001, 4'b0001, 0);
      add(1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
      // stall arriving mid-burst
      add(1, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1);
      add(1, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, 1);
      add(1, 4'b0011, 4'b0001, 0, 4'b0001, 4'b0001, 0);
      add(1, 4'b0011, 4'b0011, 0, 4'b0001, 4'b0010, 0);
      // reset mid-burst on requester 1, then restart from pointer 0
      add(1, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 1);
      add(0, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0000, 0);
      add(0, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0000, 0);
      add(1, 4'b0011, 4'b0011, 0, 4'b0001, 4'b0001, 0);
      add(1, 4'b0011, 4'b0011, 0, 4'b0001, 4'b0010, 0);
      add(1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         row = i;
         apply(vecs[i]);
      end

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
